flash_page_buffer: RTL and testbench
====================================

FLASH_PAGE_BUFFER -- requirements
Module: flash_page_buffer

Interface
REQ-001 SHALL have parameter PAGE_WORDS, default 64, words per flash page (power of two).
REQ-002 SHALL have parameter ADDR_W, default 14, flash word-address width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port DATA  input  8  parallel-programming data bus.
REQ-006 SHALL have port BS1  input  1  byte select: 0 = low byte, 1 = high byte.
REQ-007 SHALL have port EnAdrLat  input  1  address-latch enable from the programming FSM.
REQ-008 SHALL have port EnBuf  input  1  data-buffer load enable from the programming FSM.
REQ-009 SHALL have port DB_WR  input  1  write-mode qualifier; loads are accepted only while high.
REQ-010 SHALL have ports Erase and Prog  input  1 each  page-erase and page-program requests.
REQ-011 SHALL have port arr_ready  input  1  flash array accepts the current erase/write this cycle.
REQ-012 SHALL have ports arr_erase and arr_we  output  1 each  array page-erase and word-write requests.
REQ-013 SHALL have ports arr_addr  output  ADDR_W  and  arr_wdata  output  16  array word address and data.
REQ-014 SHALL have ports busy  output  1  (state not IDLE) and page_done  output  1  (one-cycle completion pulse).

Function
REQ-015 SHALL register EnAdrLat, EnBuf, Erase and Prog once and act only on a 0->1 transition seen at a clk edge; a level held for many cycles SHALL cause exactly one action.
REQ-016 A rising EnAdrLat with DB_WR=1 and busy=0 SHALL load addr_lo<=DATA when BS1=0, and addr_hi<=DATA[ADDR_W-9:0] when BS1=1.
REQ-017 A rising EnBuf with DB_WR=1, BS1=0 and busy=0 SHALL capture DATA into a low-byte holding register.
REQ-018 A rising EnBuf with DB_WR=1, BS1=1 and busy=0 SHALL write {DATA, holding} into buf[addr_lo mod PAGE_WORDS].
REQ-019 Writing the same buffer index twice SHALL overwrite the earlier value; no error is flagged.
REQ-020 Page base SHALL be {addr_hi, addr_lo} with the low log2(PAGE_WORDS) bits forced to 0.
REQ-021 The FSM SHALL have the states IDLE, ERASE, PROG and DONE.
REQ-022 In IDLE, a rising Erase SHALL go to ERASE, and a rising Prog alone SHALL go to PROG.
REQ-023 In ERASE, the block SHALL drive arr_erase=1 with arr_addr=page base until a cycle with arr_ready=1.
REQ-024 On that arr_ready cycle, ERASE SHALL exit to PROG if a Prog rise is pending, otherwise to IDLE.
REQ-025 Erase and Prog rising in the same cycle SHALL run erase then program; the Prog rise SHALL be latched as pending.
REQ-026 In PROG, the index idx SHALL start at 0 and the block SHALL drive arr_we=1, arr_addr=base+idx, arr_wdata=buf[idx].
REQ-027 idx SHALL increment only on cycles with arr_ready=1; acceptance of idx=PAGE_WORDS-1 SHALL go to DONE.
REQ-028 DONE SHALL last one cycle with page_done=1, SHALL reset every buf word to 16'hFFFF, and SHALL return to IDLE.
REQ-029 Load, Erase and Prog edges arriving while busy=1 SHALL be ignored, except a pending Prog captured per REQ-025.
REQ-030 arr_erase and arr_we SHALL never be high in the same cycle; arr_addr and arr_wdata SHALL be held stable while a request waits for arr_ready.

Reset
REQ-031 On rst=1, the block SHALL go to IDLE with arr_erase=0, arr_we=0, arr_addr=0, arr_wdata=0, busy=0 and page_done=0.
REQ-032 On rst=1, addr_lo, addr_hi, holding, idx and the pending flag SHALL clear to 0, and every buf word SHALL be set to 16'hFFFF.
REQ-033 rst asserted mid-ERASE or mid-PROG SHALL abort with no page_done pulse; outputs SHALL be low in the cycle after the rst edge.
REQ-034 Edge registers SHALL reset to 0, so an input already high when rst deasserts SHALL count as a rising edge on the first cycle.

Structure
REQ-035 A shared package SHALL hold the state enum (IDLE/ERASE/PROG/DONE), the default PAGE_WORDS and ERASED_WORD=16'hFFFF.
REQ-036 One sub-module, pp_rise_detect, SHALL be instantiated per edge-detected input: a one-register 0->1 pulse with synchronous reset.

Verification
REQ-037 Bench SHALL drive addr_hi=0x01, addr_lo=0x40, load word 0xA55A at index 0, then Prog with arr_ready=1 -> 64 arr_we cycles at addresses 0x140..0x17F, word 0 = 0xA55A, all others 0xFFFF, then one page_done pulse.
REQ-038 Bench SHALL assert Erase and Prog in the same cycle with arr_ready=1 -> one arr_erase cycle at the page base, then 64 writes, then page_done.
REQ-039 Bench SHALL stall arr_ready low for 5 cycles at idx=10 -> arr_addr and arr_wdata held constant, idx not advancing, and 64 total accepted writes.
REQ-040 Bench SHALL hold EnBuf high for 8 cycles with BS1=1 -> exactly one buffer write; the same loads with DB_WR=0 -> no change.
REQ-041 Bench SHALL assert rst at idx=20 -> arr_we=0 on the next cycle, no page_done, and a subsequent Prog writes 0xFFFF to all 64 words.

Source files
------------

// File: rtl/flash_page_buffer_pkg.sv
// Shared types and constants for the flash page buffer: FSM states, default
// geometry and the value an erased flash word reads back as.
package flash_page_buffer_pkg;

  localparam int DEF_PAGE_WORDS = 64;
  localparam int DEF_ADDR_W     = 14;
  localparam logic [15:0] ERASED_WORD = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ERASE = 2'd1,
    PROG  = 2'd2,
    DONE  = 2'd3
  } pb_state_t;

endpackage

// File: rtl/pp_rise_detect.sv
// One-register 0->1 detector; the register clears on reset so an input that is
// already high when reset releases reports a rise on the first cycle.
module pp_rise_detect (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_rise
);

  logic r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_q <= 1'b0;
    else       r_q <= i_d;
  end

  assign o_rise = i_d & ~r_q;

endmodule

// File: rtl/flash_page_buffer.sv
// Parallel-programming page buffer: collects 16-bit words byte by byte, then
// optionally erases the page and streams the buffer into the flash array.
module flash_page_buffer
  import flash_page_buffer_pkg::*;
#(
  parameter int PAGE_WORDS = DEF_PAGE_WORDS,
  parameter int ADDR_W     = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        DATA,
  input  logic              BS1,
  input  logic              EnAdrLat,
  input  logic              EnBuf,
  input  logic              DB_WR,
  input  logic              Erase,
  input  logic              Prog,
  input  logic              arr_ready,
  output logic              arr_erase,
  output logic              arr_we,
  output logic [ADDR_W-1:0] arr_addr,
  output logic [15:0]       arr_wdata,
  output logic              busy,
  output logic              page_done,
  output pb_state_t         o_state
);

  localparam int IDX_W = $clog2(PAGE_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAGE_WORDS - 1);

  // Handshake: a request (arr_erase or arr_we) with its address/data is held
  // unchanged every cycle until a cycle with arr_ready=1, where it is consumed.

  pb_state_t         r_state;
  pb_state_t         w_state_nxt;
  logic [7:0]        r_addr_lo;
  logic [ADDR_W-9:0] r_addr_hi;
  logic [7:0]        r_hold;
  logic [IDX_W-1:0]  r_idx;
  logic              r_pending;
  logic [15:0]       r_buf [PAGE_WORDS];

  logic w_adr_rise, w_buf_rise, w_erase_rise, w_prog_rise;
  logic w_load_ok;
  logic [ADDR_W-1:0] w_base;
  logic [ADDR_W-1:0] w_prog_addr;

  pp_rise_detect u_rise_adr   (.i_clk(clk), .i_rst(rst), .i_d(EnAdrLat), .o_rise(w_adr_rise));
  pp_rise_detect u_rise_buf   (.i_clk(clk), .i_rst(rst), .i_d(EnBuf),    .o_rise(w_buf_rise));
  pp_rise_detect u_rise_erase (.i_clk(clk), .i_rst(rst), .i_d(Erase),    .o_rise(w_erase_rise));
  pp_rise_detect u_rise_prog  (.i_clk(clk), .i_rst(rst), .i_d(Prog),     .o_rise(w_prog_rise));

  assign w_load_ok   = (r_state == IDLE) && DB_WR;
  assign w_base      = {r_addr_hi, r_addr_lo[7:IDX_W], {IDX_W{1'b0}}};
  assign w_prog_addr = {r_addr_hi, r_addr_lo[7:IDX_W], r_idx};
  assign busy        = (r_state != IDLE);
  assign o_state     = r_state;

  always_comb begin
    w_state_nxt = r_state;
    arr_erase   = 1'b0;
    arr_we      = 1'b0;
    arr_addr    = '0;
    arr_wdata   = '0;
    page_done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_erase_rise)     w_state_nxt = ERASE;
        else if (w_prog_rise) w_state_nxt = PROG;
      end
      ERASE: begin
        arr_erase = 1'b1;
        arr_addr  = w_base;
        if (arr_ready) w_state_nxt = r_pending ? PROG : IDLE;
      end
      PROG: begin
        arr_we    = 1'b1;
        arr_addr  = w_prog_addr;
        arr_wdata = r_buf[r_idx];
        if (arr_ready && (r_idx == LAST_IDX)) w_state_nxt = DONE;
      end
      DONE: begin
        page_done   = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_addr_lo <= '0;
      r_addr_hi <= '0;
      r_hold    <= '0;
      r_idx     <= '0;
      r_pending <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_ok && w_adr_rise) begin
        if (BS1) r_addr_hi <= DATA[ADDR_W-9:0];
        else     r_addr_lo <= DATA;
      end
      if (w_load_ok && w_buf_rise && !BS1) r_hold <= DATA;
      case (r_state)
        IDLE: begin
          // Only a Prog rising together with Erase is remembered for later.
          if (w_erase_rise) begin
            r_pending <= w_prog_rise;
            r_idx     <= '0;
          end else if (w_prog_rise) begin
            r_idx <= '0;
          end
        end
        ERASE: if (arr_ready) begin
          r_pending <= 1'b0;
          r_idx     <= '0;
        end
        PROG: if (arr_ready) r_idx <= r_idx + 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (r_state == DONE)) begin
      for (int i = 0; i < PAGE_WORDS; i++) r_buf[i] <= ERASED_WORD;
    end else if (w_load_ok && w_buf_rise && BS1) begin
      r_buf[r_addr_lo[IDX_W-1:0]] <= {DATA, r_hold};
    end
  end

endmodule

// File: tb/tb_flash_page_buffer.sv
// Bench for flash_page_buffer: table-driven page programs, hand-written corner
// sequences and randomized loads checked against a page-level reference model.
module tb_flash_page_buffer;
  import flash_page_buffer_pkg::*;

  localparam int XW = 1 + 14 + 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  DATA = '0;
  logic        BS1 = 1'b0, EnAdrLat = 1'b0, EnBuf = 1'b0, DB_WR = 1'b0;
  logic        Erase = 1'b0, Prog = 1'b0, arr_ready = 1'b0;
  logic        arr_erase, arr_we, busy, page_done;
  logic [13:0] arr_addr;
  logic [15:0] arr_wdata;
  pb_state_t   dbg_state;

  flash_page_buffer dut (
    .clk(clk), .rst(rst), .DATA(DATA), .BS1(BS1), .EnAdrLat(EnAdrLat),
    .EnBuf(EnBuf), .DB_WR(DB_WR), .Erase(Erase), .Prog(Prog),
    .arr_ready(arr_ready), .arr_erase(arr_erase), .arr_we(arr_we),
    .arr_addr(arr_addr), .arr_wdata(arr_wdata), .busy(busy),
    .page_done(page_done), .o_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Reference model: page buffer contents and the latched address/holding bytes.
  logic [15:0] m_buf [64];
  logic [7:0]  m_lo, m_hold;
  logic [5:0]  m_hi;

  logic [XW-1:0] exp_q[$];
  logic [13:0]   cap_addr [64];
  logic [15:0]   cap_data [64];
  int n_cmp = 0, n_bad = 0, n_acc = 0, n_done = 0, d0 = 0;
  logic        prev_wait = 1'b0;
  logic [13:0] prev_addr = '0;
  logic [15:0] prev_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_lo = '0; m_hi = '0; m_hold = '0;
    for (int i = 0; i < 64; i++) m_buf[i] = 16'hFFFF;
  endtask

  task automatic mon();
    logic [XW-1:0] e;
    if (rst) begin
      prev_wait = 1'b0;
    end else begin
      if (arr_we || arr_erase) check("one_request", 32'(arr_we & arr_erase), 32'd0);
      if (prev_wait && (arr_we || arr_erase)) begin
        check("hold_addr", 32'(arr_addr), 32'(prev_addr));
        check("hold_data", 32'(arr_wdata), 32'(prev_data));
      end
      if ((arr_we || arr_erase) && arr_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_xfer: got %0h expected none", {arr_erase, arr_addr, arr_wdata});
        end else begin
          e = exp_q.pop_front();
          check("xfer", 32'({arr_erase, arr_addr, arr_wdata}), 32'(e));
        end
        if (arr_we) begin
          if (n_acc < 64) begin
            cap_addr[n_acc] = arr_addr;
            cap_data[n_acc] = arr_wdata;
          end
          n_acc++;
        end
      end
      if (page_done) n_done++;
      prev_wait = (arr_we || arr_erase) && !arr_ready;
      prev_addr = arr_addr;
      prev_data = arr_wdata;
    end
  endtask

  task automatic step();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic adr_byte(input bit bs, input logic [7:0] d);
    DB_WR = 1'b1; BS1 = bs; DATA = d; EnAdrLat = 1'b1;
    step();
    EnAdrLat = 1'b0;
    step();
    DB_WR = 1'b0;
    if (bs) m_hi = d[5:0];
    else    m_lo = d;
  endtask

  task automatic load_addr(input logic [5:0] hi, input logic [7:0] lo);
    adr_byte(1'b1, {2'b00, hi});
    adr_byte(1'b0, lo);
  endtask

  // Holds EnBuf for 'hold' cycles while DATA wanders; only the first byte counts.
  task automatic buf_byte(input bit bs, input logic [7:0] d, input bit wr, input int hold);
    DB_WR = wr; BS1 = bs; DATA = d; EnBuf = 1'b1;
    step();
    for (int i = 1; i < hold; i++) begin
      DATA = 8'($urandom);
      step();
    end
    EnBuf = 1'b0;
    step();
    DB_WR = 1'b0;
    if (wr) begin
      if (bs) m_buf[m_lo[5:0]] = {d, m_hold};
      else    m_hold = d;
    end
  endtask

  task automatic load_word(input logic [15:0] w);
    buf_byte(1'b0, w[7:0], 1'b1, 1);
    buf_byte(1'b1, w[15:8], 1'b1, 1);
  endtask

  task automatic push_page(input bit e, input bit p);
    logic [13:0] base;
    base = {m_hi, m_lo} & ~14'd63;
    if (e) exp_q.push_back({1'b1, base, 16'h0000});
    if (p) begin
      for (int i = 0; i < 64; i++) exp_q.push_back({1'b0, base + 14'(i), m_buf[i]});
      for (int i = 0; i < 64; i++) m_buf[i] = 16'hFFFF;
    end
    n_acc = 0;
    d0 = n_done;
    for (int i = 0; i < 64; i++) begin cap_addr[i] = '0; cap_data[i] = '0; end
  endtask

  task automatic start_op(input bit e, input bit p);
    push_page(e, p);
    Erase = e; Prog = p;
    step();
    Erase = 1'b0; Prog = 1'b0;
  endtask

  // mode 0: always ready; mode 1: random ready plus ignored load/command noise.
  task automatic drain(input int mode, input int stall_at, input int rst_at);
    int guard = 0;
    int stall = 0;
    bit did_rst = 1'b0;
    while (busy && guard < 3000) begin
      guard++;
      EnBuf = 1'b0; EnAdrLat = 1'b0; Erase = 1'b0; Prog = 1'b0; DB_WR = 1'b0;
      arr_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mode == 1 && n_acc >= 1 && n_acc < 60 && $urandom_range(0, 3) == 0) begin
        DB_WR = 1'b1; BS1 = 1'($urandom); DATA = 8'($urandom);
        EnBuf = 1'($urandom); EnAdrLat = 1'($urandom);
        Erase = 1'($urandom); Prog = 1'($urandom);
      end
      if (stall_at >= 0 && n_acc == stall_at && stall < 5) begin
        arr_ready = 1'b0;
        stall++;
      end
      if (rst_at >= 0 && n_acc == rst_at && !did_rst) begin
        did_rst = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_we", 32'(arr_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_addr", 32'(arr_addr), 32'd0);
        exp_q.delete();
        model_reset();
      end else begin
        step();
      end
    end
    if (guard >= 3000) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: got busy=%0d expected idle", busy);
    end
    EnBuf = 1'b0; EnAdrLat = 1'b0; Erase = 1'b0; Prog = 1'b0; DB_WR = 1'b0;
    arr_ready = 1'b0;
    step();
  endtask

  task automatic page_checks();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("done_pulses", 32'(n_done - d0), 32'd1);
    check("idle_after", 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [5:0]  hi;
    logic [7:0]  lo;
    logic [15:0] word;
    bit          erase;
    logic [13:0] exp_base;
    int          exp_idx;
  } vec_t;

  vec_t vecs [4];

  initial begin
    vecs[0] = '{hi: 6'h01, lo: 8'h40, word: 16'hA55A, erase: 1'b0, exp_base: 14'h0140, exp_idx: 0};
    vecs[1] = '{hi: 6'h01, lo: 8'h40, word: 16'h0F0F, erase: 1'b1, exp_base: 14'h0140, exp_idx: 0};
    vecs[2] = '{hi: 6'h3F, lo: 8'hFF, word: 16'h1234, erase: 1'b0, exp_base: 14'h3FC0, exp_idx: 63};
    vecs[3] = '{hi: 6'h2A, lo: 8'h85, word: 16'hBEEF, erase: 1'b1, exp_base: 14'h2A80, exp_idx: 5};

    model_reset();
    step();
    step();
    check("rst_erase", 32'(arr_erase), 32'd0);
    check("rst_we0", 32'(arr_we), 32'd0);
    check("rst_addr0", 32'(arr_addr), 32'd0);
    check("rst_wdata", 32'(arr_wdata), 32'd0);
    check("rst_busy0", 32'(busy), 32'd0);
    check("rst_done", 32'(page_done), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    step();

    for (int v = 0; v < 4; v++) begin
      load_addr(vecs[v].hi, vecs[v].lo);
      load_word(vecs[v].word);
      start_op(vecs[v].erase, 1'b1);
      drain(0, -1, -1);
      page_checks();
      check("first_addr", 32'(cap_addr[0]), 32'(vecs[v].exp_base));
      check("last_addr", 32'(cap_addr[63]), 32'(vecs[v].exp_base) + 32'd63);
      check("word_at_idx", 32'(cap_data[vecs[v].exp_idx]), 32'(vecs[v].word));
    end

    // Stall ready for five cycles while word 10 is offered.
    load_addr(6'h01, 8'h4A);
    load_word(16'h5AA5);
    start_op(1'b0, 1'b1);
    drain(0, 10, -1);
    page_checks();
    check("stall_count", 32'(n_acc), 32'd64);
    check("stall_word", 32'(cap_data[10]), 32'h5AA5);

    // Held enables act once; the same loads with DB_WR low change nothing.
    load_addr(6'h02, 8'h13);
    buf_byte(1'b0, 8'h34, 1'b1, 8);
    buf_byte(1'b1, 8'h12, 1'b1, 8);
    buf_byte(1'b0, 8'h77, 1'b0, 8);
    buf_byte(1'b1, 8'h66, 1'b0, 8);
    start_op(1'b0, 1'b1);
    drain(0, -1, -1);
    page_checks();
    check("held_word", 32'(cap_data[19]), 32'h1234);
    check("held_base", 32'(cap_addr[0]), 32'h0200);

    // Reset in the middle of programming, then program the cleared buffer.
    load_addr(6'h05, 8'h00);
    load_word(16'hC0DE);
    start_op(1'b0, 1'b1);
    drain(0, -1, 20);
    check("abort_no_done", 32'(n_done - d0), 32'd0);
    start_op(1'b0, 1'b1);
    drain(0, -1, -1);
    page_checks();
    check("post_rst_word0", 32'(cap_data[0]), 32'hFFFF);
    check("post_rst_base", 32'(cap_addr[0]), 32'd0);

    // Randomized loads, optional erase, random ready and ignored noise.
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 4; k++) begin
        adr_byte(1'b0, 8'($urandom));
        load_word(16'($urandom));
      end
      adr_byte(1'b1, 8'($urandom_range(0, 63)));
      start_op(1'($urandom), 1'b1);
      drain(1, -1, -1);
      page_checks();
    end

    // Prog already high when reset releases counts as a rise.
    rst = 1'b1; Prog = 1'b1;
    step();
    model_reset();
    exp_q.delete();
    rst = 1'b0;
    push_page(1'b0, 1'b1);
    step();
    check("rise_after_rst", 32'(busy), 32'd1);
    drain(0, -1, -1);
    page_checks();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
